// File: rtl/instruction_issuer_if.sv
// Command/instruction bundle between the command source, the issuer and the player.
interface instruction_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic [3:0]  dir;
  logic        move_tick;
  logic [15:0] instruction;
  logic        issued;
  logic        bad_cmd;
  logic [7:0]  issue_count;

  // Command source / player side
  modport master (
    output cmd_valid, cmd_op, cmd_arg, dir, move_tick,
    input  cmd_ready, instruction, issued, bad_cmd, issue_count
  );

  // Issuer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dir, move_tick,
    output cmd_ready, instruction, issued, bad_cmd, issue_count
  );
endinterface

// File: rtl/instruction_issuer.sv
// Instruction issuer: queues player commands in a 4-entry FIFO and merges them
// with movement requests into one registered instruction word per cycle.
// Movement on a move_tick cycle wins over the queue so the player's movement
// sample always sees a move word; queued commands drain otherwise.
module instruction_issuer (
  input logic                 clk,
  input logic                 reset,
  instruction_issuer_if.slave bus
);
  localparam logic [2:0] FULL_COUNT = 3'd4;
  localparam logic [3:0] MOVE_OP    = 4'h5;

  // Four entries of {op, arg}; small enough to live in registers.
  logic [11:0] fifo_mem [0:3];
  logic [1:0]  wr_ptr_reg;
  logic [1:0]  rd_ptr_reg;
  logic [2:0]  count_reg;

  logic [15:0] instruction_reg;
  logic [15:0] instruction_next;
  logic        issued_reg;
  logic        issued_next;
  logic        bad_cmd_reg;
  logic [7:0]  issue_count_reg;

  logic        accept;
  logic        op_legal;
  logic        push;
  logic        pop;
  logic        dir_any;
  logic        tick_move;
  logic [1:0]  move_code;
  logic [15:0] move_word;
  logic [11:0] head;

  // Ready depends on registered occupancy only, so a same-cycle pop never opens a full queue.
  assign bus.cmd_ready = (count_reg != FULL_COUNT);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign push          = accept && op_legal;

  assign dir_any   = (bus.dir != 4'd0);
  assign tick_move = bus.move_tick && dir_any;
  assign head      = fifo_mem[rd_ptr_reg];
  assign move_word = {MOVE_OP, 6'd0, move_code, 4'h0};

  // Legal opcodes: heal, damage, ATK increment, ATK set, HP set.
  always_comb begin
    op_legal = 1'b0;
    case (bus.cmd_op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd6: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  end

  // Lowest set direction bit wins: left, up, right, down.
  always_comb begin
    move_code = 2'd0;
    if (bus.dir[0])      move_code = 2'd0;
    else if (bus.dir[1]) move_code = 2'd1;
    else if (bus.dir[2]) move_code = 2'd2;
    else if (bus.dir[3]) move_code = 2'd3;
  end

  // Fixed-priority selection of the next instruction word.
  always_comb begin
    instruction_next = 16'h0000;
    issued_next      = 1'b0;
    pop              = 1'b0;
    if (tick_move) begin
      instruction_next = move_word;
    end else if (count_reg != 3'd0) begin
      instruction_next = {head, 4'h0};
      issued_next      = 1'b1;
      pop              = 1'b1;
    end else if (dir_any) begin
      instruction_next = move_word;
    end
  end

  // Queue storage write; stale entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.cmd_op, bus.cmd_arg};
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      if (push && !pop)      count_reg <= count_reg + 3'd1;
      else if (pop && !push) count_reg <= count_reg - 3'd1;
    end
  end

  // Output registers: instruction word, issue pulse, illegal-command pulse, wrapping issue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_reg <= 16'h0000;
      issued_reg      <= 1'b0;
      bad_cmd_reg     <= 1'b0;
      issue_count_reg <= 8'd0;
    end else begin
      instruction_reg <= instruction_next;
      issued_reg      <= issued_next;
      bad_cmd_reg     <= accept && !op_legal;
      if (pop) issue_count_reg <= issue_count_reg + 8'd1;
    end
  end

  assign bus.instruction = instruction_reg;
  assign bus.issued      = issued_reg;
  assign bus.bad_cmd     = bad_cmd_reg;
  assign bus.issue_count = issue_count_reg;
endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboard bench for instruction_issuer: the driver runs a queue-level model of
// the issuer and pushes the expected output of each clock edge; a monitor pops
// and compares after every edge.
module tb_instruction_issuer;
  logic clk;
  logic reset;

  instruction_issuer_if bus ();

  instruction_issuer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        issued;
    logic        bad;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q [$];
  logic [11:0] model_q [$];
  logic [7:0]  model_issues;
  int          checks;
  int          errors;
  logic [3:0]  legal_ops [5];

  // Queue-level reference: one call per clock edge, predicts the outputs after that edge.
  task automatic model_edge(input logic rst, input logic v, input logic [3:0] op,
                            input logic [7:0] arg, input logic [3:0] d, input logic tk);
    exp_t        e;
    logic [1:0]  code;
    logic        accepted;
    logic        legal;
    logic [15:0] mv;
    code = 2'd0;
    for (int i = 3; i >= 0; i--) if (d[i]) code = 2'(i);
    mv = {4'h5, 6'd0, code, 4'h0};
    if (rst) begin
      model_q.delete();
      model_issues = 8'd0;
      e.instr  = 16'h0000;
      e.issued = 1'b0;
      e.bad    = 1'b0;
    end else begin
      accepted = v && (model_q.size() < 4);
      legal    = (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4) || (op == 4'd6);
      e.issued = 1'b0;
      if (tk && d != 4'd0) begin
        e.instr = mv;
      end else if (model_q.size() > 0) begin
        e.instr      = {model_q.pop_front(), 4'h0};
        e.issued     = 1'b1;
        model_issues = model_issues + 8'd1;
      end else if (d != 4'd0) begin
        e.instr = mv;
      end else begin
        e.instr = 16'h0000;
      end
      if (accepted && legal) model_q.push_back({op, arg});
      e.bad = accepted && !legal;
    end
    e.cnt = model_issues;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, driven on the falling edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [7:0] arg, input logic [3:0] d, input logic tk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== (model_q.size() != 4)) begin
      errors++;
      $display("FAIL cmd_ready: got %b want %b at %0t", bus.cmd_ready, (model_q.size() != 4), $time);
    end
    reset         = rst;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.dir       = d;
    bus.move_tick = tk;
    $display("cyc t=%0t rst=%b v=%b op=%0d arg=%02h dir=%b tick=%b", $time, rst, v, op, arg, d, tk);
    model_edge(rst, v, op, arg, d, tk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 4'd0, 1'b0);
  endtask

  // Monitor: compare every registered output just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (bus.instruction !== e.instr) begin
          errors++;
          $display("FAIL instruction: got %04h want %04h at %0t", bus.instruction, e.instr, $time);
        end
        if (bus.issued !== e.issued) begin
          errors++;
          $display("FAIL issued: got %b want %b at %0t", bus.issued, e.issued, $time);
        end
        if (bus.bad_cmd !== e.bad) begin
          errors++;
          $display("FAIL bad_cmd: got %b want %b at %0t", bus.bad_cmd, e.bad, $time);
        end
        if (bus.issue_count !== e.cnt) begin
          errors++;
          $display("FAIL issue_count: got %0d want %0d at %0t", bus.issue_count, e.cnt, $time);
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic [3:0] d;
    checks       = 0;
    errors       = 0;
    model_issues = 8'd0;
    legal_ops    = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_arg   = 8'd0;
    bus.dir       = 4'd0;
    bus.move_tick = 1'b0;

    // Reset, then idle with no direction.
    step(1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 4'd1, 8'd5, 4'd2, 1'b1);
    idle(3);

    // Heal 25 into an empty queue.
    step(1'b0, 1'b1, 4'd1, 8'h19, 4'd0, 1'b0);
    idle(4);

    // Five pushes while move_tick blocks draining; then release.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, legal_ops[i % 5], 8'(8'h30 + i), 4'b0100, 1'b1);
    step(1'b0, 1'b0, 4'd0, 8'd0, 4'b0100, 1'b1);
    idle(6);

    // Damage 10 and ATK set 20 queued, move_tick in the first pop cycle.
    step(1'b0, 1'b1, 4'd2, 8'h0A, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'd4, 8'h14, 4'b0001, 1'b1);
    step(1'b0, 1'b0, 4'd0, 8'd0, 4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 4'b0001, 1'b0);
    idle(2);

    // Illegal opcodes 5 and 0, plus operand-0 heal.
    step(1'b0, 1'b1, 4'd5, 8'h11, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 8'h22, 4'd0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 4'd1, 8'h00, 4'd0, 1'b0);
    idle(3);

    // Three commands queued, then a one-cycle reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd3, 8'(i + 1), 4'b1000, 1'b1);
    step(1'b1, 1'b1, 4'd6, 8'h77, 4'b1000, 1'b1);
    idle(5);

    // Long reset-free burst so issue_count wraps past 255.
    for (int i = 0; i < 700; i++) begin
      op = legal_ops[$urandom_range(0, 4)];
      d  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step(1'b0, ($urandom_range(0, 7) != 0), op, 8'($urandom), d, ($urandom_range(0, 9) == 0));
    end

    // Fully random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
      d  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), op, 8'($urandom),
           d, ($urandom_range(0, 3) == 0));
    end

    idle(3);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
